ycc422_rgb_sequencer: RTL and testbench
=======================================

# ycc422_rgb_sequencer

Streaming front end for the display path. It accepts packed YCbCr 4:2:2 words (two pixels sharing one chroma pair) and time-multiplexes a single combinational `ycbcr2rgb` converter across both pixels. It emits one registered 24-bit RGB pixel per cycle under valid/ready flow control, with line and frame position flags. It sits between the frame-buffer read FIFO and the VGA pixel FIFO.

## Interface

**Parameters**
- `LINE_PIXELS`, default 640: pixels per line. Must be even.
- `FRAME_LINES`, default 480: lines per frame.

**Ports**
- `clock`  in  1  system clock. Only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  32  packed word: `[31:24]` Y0, `[23:16]` Cb, `[15:8]` Y1, `[7:0]` Cr.
- `in_sof`  in  1  the word is the first word of a frame. Qualified by `in_valid`.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_rgb`  out  24  `{r,g,b}`, 8 bits each.
- `out_sof`  out  1  pixel is at x=0, y=0.
- `out_eol`  out  1  pixel is at x=`LINE_PIXELS`-1.
- `out_eof`  out  1  pixel is the last pixel of the frame.
- `sync_err`  out  1  sticky flag. Set when `in_sof` arrives at the wrong position.

## Operation

**Transfers**
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- `slot_free` = `!out_valid || out_ready`.

**FSM states: EMPTY, P0, P1**
- EMPTY
  - `in_ready`=1.
  - On transfer: capture `in_data` and `in_sof` into the hold register, go to P0.
- P0
  - Converter is driven with (Y0, Cb, Cr).
  - If `slot_free`: load the output register with the result and flags, go to P1. Otherwise stay in P0.
- P1
  - Converter is driven with (Y1, Cb, Cr).
  - `in_ready` = `slot_free`.
  - If `slot_free`: load the output register.
    - If an input transfer also occurs: capture the new word, go to P0.
    - Otherwise go to EMPTY.
  - If not `slot_free`: stay in P1.
- The hold register changes only on an input transfer.

**Position tracking**
- Counters `x` (0..`LINE_PIXELS`-1) and `y` (0..`FRAME_LINES`-1) give the position of the next pixel loaded into the output register.
- On each load: `x` increments. At `LINE_PIXELS`-1, `x` wraps to 0 and `y` increments. At `FRAME_LINES`-1, `y` wraps to 0.
- The flags are computed from `x` and `y` at load time and registered alongside `out_rgb`.

**Resynchronisation**
- Applies when the P0 load is of a word captured with `in_sof`=1.
- If (`x`,`y`) ≠ (0,0): set `sync_err`, and force this pixel to position (0,0), so `out_sof`=1 and counting continues from x=1.
- If (`x`,`y`) = (0,0): no action.
- A word without `in_sof` arriving at (0,0) is not an error.

**Arithmetic**
- All colour arithmetic and clamping to 0..255 is done inside `ycbcr2rgb`. No additional rounding.

**Reset**
- Reset values: state EMPTY, `out_valid`=0, `out_rgb`=0, all flags 0, `sync_err`=0, `x`=`y`=0, hold register 0.
- `in_ready` reads 1 immediately after reset because it is combinational from state.
- Reset in any state discards the held word and any pending output pixel. No partial pixel is emitted afterwards.

## Timing

- Word accepted at edge k. Pixel 0 has `out_valid` from edge k+1. Pixel 1 is loaded at edge k+2 if `out_ready` was high in cycle k+1.
- Sustained throughput is 1 pixel/cycle: a new word is accepted every second cycle in P1.
- `out_rgb` and the flags remain stable while `out_valid && !out_ready`.
- `in_ready` has a combinational path from `out_ready`, taken only in P1. No other combinational input-to-output paths exist.
- The converter path is a single combinational stage between the hold register and the output register.

## Structure

- Shared header `augreal_defs.vh` holds:
  - `in_data` field positions.
  - FSM state encodings.
  - Default `LINE_PIXELS` and `FRAME_LINES`.
- The one sub-module is `ycbcr2rgb`, instantiated once.
- Y and Cb/Cr selection into the converter is a 2:1 mux keyed on the state.

## Test plan

- **Basic conversion.** Word Y0=0x10, Cb=0x80, Y1=0xEB, Cr=0x80, `out_ready`=1 → pixel 0x000000, then 0xFEFEFE. Two `out_valid` cycles.
- **Saturation.** Y0=Y1=0xFF, Cb=0x80, Cr=0xFF → both pixels 0xFFAEFF (R and B clamped).
- **Backpressure.** Stream 4 words and hold `out_ready`=0 for 5 cycles mid-stream → no pixel lost or duplicated, `out_rgb` stable while stalled, `in_ready`=0 during the stall.
- **Flags.** `LINE_PIXELS`=4, `FRAME_LINES`=2, 4 words with `in_sof` on the first → `out_sof` on pixel 0, `out_eol` on pixels 3 and 7, `out_eof` on pixel 7, `sync_err`=0.
- **Resync.** `in_sof` on the second word (position x=2) → `sync_err` rises and stays high, that word's pixel 0 shows `out_sof`=1, and the next `out_eol` falls 3 pixels later.
- **Reset mid-operation.** Assert `reset` in P1 with `out_valid`=1 → `out_valid` drops asynchronously, `in_ready`=1 after release, the next accepted word produces its pixels at position (0,0).

Source files
------------

// File: rtl/ycc422_rgb_sequencer_pkg.sv
// Shared definitions for the YCbCr 4:2:2 -> RGB sequencer.
// Holds the packed input word field positions, the FSM state encodings,
// the default raster size, and the pixel structs used between the
// converter and the output register.
package ycc422_rgb_sequencer_pkg;

  // in_data layout: [31:24] Y0, [23:16] Cb, [15:8] Y1, [7:0] Cr
  localparam int WORD_W = 32;
  localparam int RGB_W  = 24;
  localparam int Y0_LSB = 24;
  localparam int CB_LSB = 16;
  localparam int Y1_LSB = 8;
  localparam int CR_LSB = 0;

  // FSM encodings
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_P0    = 2'd1;
  localparam logic [1:0] ST_P1    = 2'd2;

  localparam int DEF_LINE_PIXELS = 640;
  localparam int DEF_FRAME_LINES = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic sof;
    logic eol;
    logic eof;
  } pix_t;

  function automatic logic [7:0] field8(input logic [WORD_W-1:0] w, input int lsb);
    return w[lsb +: 8];
  endfunction

endpackage

// File: rtl/ycc422_rgb_sequencer_if.sv
// Stream bundle for the sequencer: YCbCr word input side, RGB pixel output
// side and the sticky sync error flag.
//   slave  : the sequencer (consumes words, produces pixels)
//   master : the environment (frame-buffer FIFO / VGA FIFO side)
interface ycc422_rgb_sequencer_if;
  import ycc422_rgb_sequencer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [RGB_W-1:0]  out_rgb;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic              sync_err;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_rgb, out_sof, out_eol, out_eof, sync_err
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_rgb, out_sof, out_eol, out_eof, sync_err
  );
endinterface

// File: rtl/ycc422_rgb_sequencer_ycbcr2rgb.sv
// Combinational BT.601 studio-range YCbCr -> RGB converter.
// Coefficients are fixed point in 1/1024 units (1.164, 1.596, 0.813,
// 0.391, 2.018); results are floored and clamped to 0..255.
//   y, cb, cr : 8-bit components
//   rgb       : {r,g,b}, 8 bits each
module ycbcr2rgb
  import ycc422_rgb_sequencer_pkg::*;
(
  input  logic [7:0] y,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  output rgb_t       rgb
);

  logic signed [22:0] yd, cbd, crd;
  logic signed [22:0] yt, r_acc, g_acc, b_acc;

  assign yd  = $signed({15'd0, y})  - 23'sd16;
  assign cbd = $signed({15'd0, cb}) - 23'sd128;
  assign crd = $signed({15'd0, cr}) - 23'sd128;

  assign yt    = 23'sd1192 * yd;
  assign r_acc = yt + 23'sd1634 * crd;
  assign g_acc = yt - 23'sd833 * crd - 23'sd400 * cbd;
  assign b_acc = yt + 23'sd2066 * cbd;

  // 261120 = 255 << 10; bits [17:10] are the floored integer part
  function automatic logic [7:0] clamp(input logic signed [22:0] a);
    if (a < 23'sd0)       return 8'd0;
    if (a >= 23'sd261120) return 8'hFF;
    return a[17:10];
  endfunction

  assign rgb.r = clamp(r_acc);
  assign rgb.g = clamp(g_acc);
  assign rgb.b = clamp(b_acc);

endmodule

// File: rtl/ycc422_rgb_sequencer.sv
// YCbCr 4:2:2 -> RGB streaming sequencer.
// Accepts one packed word (two pixels sharing Cb/Cr) and time-multiplexes
// a single converter over both pixels, emitting one registered RGB pixel
// per cycle with line/frame position flags.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : in_valid/in_ready/in_data/in_sof word input,
//                  out_valid/out_ready/out_rgb/out_sof/out_eol/out_eof
//                  pixel output, sticky sync_err
module ycc422_rgb_sequencer
  import ycc422_rgb_sequencer_pkg::*;
#(
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int FRAME_LINES = DEF_FRAME_LINES
) (
  input logic                    clock,
  input logic                    reset,
  ycc422_rgb_sequencer_if.slave  bus
);

  localparam int XW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);

  logic [1:0]        state, state_nx;
  logic [WORD_W-1:0] hold_data;
  logic              hold_sof;
  logic [XW-1:0]     x, x_ld, x_nx;
  logic [YW-1:0]     y, y_ld, y_nx;
  logic              slot_free, in_fire, load, resync;
  logic [7:0]        y_sel, cb_sel, cr_sel;
  rgb_t              conv;
  pix_t              pix_d, pix_q;
  logic              out_valid_q, sync_err_q;

  assign slot_free = !out_valid_q || bus.out_ready;

  // Only P1 exposes a combinational out_ready -> in_ready path
  assign bus.in_ready = (state == ST_EMPTY) || ((state == ST_P1) && slot_free);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign load         = ((state == ST_P0) || (state == ST_P1)) && slot_free;

  // Chroma is shared; only luma is muxed on the pixel slot
  assign y_sel  = (state == ST_P1) ? field8(hold_data, Y1_LSB) : field8(hold_data, Y0_LSB);
  assign cb_sel = field8(hold_data, CB_LSB);
  assign cr_sel = field8(hold_data, CR_LSB);

  ycbcr2rgb u_conv (
    .y   (y_sel),
    .cb  (cb_sel),
    .cr  (cr_sel),
    .rgb (conv)
  );

  // A start-of-frame word landing off-origin snaps its first pixel to (0,0)
  assign resync = (state == ST_P0) && hold_sof && ((x != '0) || (y != '0));
  assign x_ld   = resync ? '0 : x;
  assign y_ld   = resync ? '0 : y;

  always_comb begin
    pix_d.rgb = conv;
    pix_d.sof = (x_ld == '0) && (y_ld == '0);
    pix_d.eol = (x_ld == X_LAST);
    pix_d.eof = (x_ld == X_LAST) && (y_ld == Y_LAST);
    x_nx      = x_ld + 1'b1;
    y_nx      = y_ld;
    if (x_ld == X_LAST) begin
      x_nx = '0;
      y_nx = (y_ld == Y_LAST) ? '0 : y_ld + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (in_fire)   state_nx = ST_P0;
      ST_P0:    if (slot_free) state_nx = ST_P1;
      ST_P1:    if (slot_free) state_nx = in_fire ? ST_P0 : ST_EMPTY;
      default:                 state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_EMPTY;
      hold_data   <= '0;
      hold_sof    <= 1'b0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
      x           <= '0;
      y           <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_fire) begin
        hold_data <= bus.in_data;
        hold_sof  <= bus.in_sof;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        pix_q       <= pix_d;
        x           <= x_nx;
        y           <= y_nx;
        if (resync) sync_err_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_rgb   = pix_q.rgb;
  assign bus.out_sof   = pix_q.sof;
  assign bus.out_eol   = pix_q.eol;
  assign bus.out_eof   = pix_q.eof;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_ycc422_rgb_sequencer.sv
// Self-checking bench for ycc422_rgb_sequencer on a 4x2 raster.
// A word-level reference model expands each accepted word into two
// expected pixels (colour + position flags + cumulative sync error);
// a negedge monitor compares every displayed pixel against it.
module tb_ycc422_rgb_sequencer;

  localparam int LP = 4;
  localparam int FL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ycc422_rgb_sequencer_if bus ();

  ycc422_rgb_sequencer #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] rgb;
    logic sof, eol, eof, err;
  } px_t;

  px_t q[$];
  px_t obs[$];
  int  n_chk = 0, n_pass = 0;
  int  mx = 0, my = 0;
  bit  merr = 1'b0;
  bit  mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // BT.601 studio range, coefficients in 1/1024 units, floor then clamp
  function automatic logic [7:0] clamp8(input real v);
    int i;
    i = int'($floor(v));
    if (i < 0) return 8'd0;
    if (i > 255) return 8'hFF;
    return i[7:0];
  endfunction

  function automatic logic [23:0] ref_rgb(input int yy, input int cb, input int cr);
    real l;
    l = 1192.0 * (yy - 16);
    return {clamp8((l + 1634.0 * (cr - 128)) / 1024.0),
            clamp8((l - 833.0 * (cr - 128) - 400.0 * (cb - 128)) / 1024.0),
            clamp8((l + 2066.0 * (cb - 128)) / 1024.0)};
  endfunction

  task automatic model_word(input logic [31:0] w, input bit sof);
    px_t e;
    for (int p = 0; p < 2; p++) begin
      if (p == 0 && sof && (mx != 0 || my != 0)) begin
        merr = 1'b1; mx = 0; my = 0;
      end
      e.rgb = ref_rgb(int'(p ? w[15:8] : w[31:24]), int'(w[23:16]), int'(w[7:0]));
      e.sof = (mx == 0 && my == 0);
      e.eol = (mx == LP - 1);
      e.eof = (mx == LP - 1) && (my == FL - 1);
      e.err = merr;
      q.push_back(e);
      mx++;
      if (mx == LP) begin mx = 0; my = (my + 1) % FL; end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (q.size() == 0) begin
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_err", 32'(bus.sync_err), 32'(merr));
      end else if (bus.out_valid) begin
        chk("rgb", 32'(bus.out_rgb), 32'(q[0].rgb));
        chk("flags", 32'({bus.out_sof, bus.out_eol, bus.out_eof}),
            32'({q[0].sof, q[0].eol, q[0].eof}));
        chk("sync_err", 32'(bus.sync_err), 32'(q[0].err));
        if (!bus.out_ready && q.size() >= 2) chk("stall_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) begin
          obs.push_back({bus.out_rgb, bus.out_sof, bus.out_eol, bus.out_eof, bus.sync_err});
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) model_word(bus.in_data, bus.in_sof);
    end
  end

  function automatic px_t ob(input int i);
    px_t z;
    z = 'x;
    if (i < obs.size()) return obs[i];
    return z;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_word(input logic [31:0] w, input bit sof);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = w; bus.in_sof = sof;
    while (!done && n < 200) begin
      @(negedge clock); done = bus.in_ready;
      @(posedge clock); #1; n++;
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_obs(input int n);
    int k;
    k = 0;
    while (obs.size() < n && k < 200) begin @(posedge clock); #1; k++; end
    if (obs.size() < n) chk("obs_timeout", 32'(obs.size()), 32'(n));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 400) begin @(posedge clock); #1; k++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sofv, eolv, eofv;
    bit drv_done;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;

    #2;
    chk("rst_valid0", 32'(bus.out_valid), 32'd0);
    chk("rst_ready0", 32'(bus.in_ready), 32'd1);
    chk("rst_err0", 32'(bus.sync_err), 32'd0);
    chk("rst_rgb0", 32'(bus.out_rgb), 32'd0);
    chk("rst_flags0", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 32'd0);
    repeat (2) @(posedge clock);
    #1; reset = 1'b0; mon_en = 1'b1;
    @(posedge clock); #1;

    // Flags over one 4x2 frame
    obs.delete();
    for (int i = 0; i < 4; i++) send_word($urandom, i == 0);
    wait_obs(8);
    for (int i = 0; i < 8; i++) begin
      sofv[i] = ob(i).sof; eolv[i] = ob(i).eol; eofv[i] = ob(i).eof;
    end
    chk("flag_sof", 32'(sofv), 32'h01);
    chk("flag_eol", 32'(eolv), 32'h88);
    chk("flag_eof", 32'(eofv), 32'h80);
    chk("flag_err", 32'(bus.sync_err), 32'd0);

    // Basic conversion
    obs.delete();
    send_word(32'h1080_EB80, 1'b0);
    wait_obs(2);
    repeat (3) begin @(posedge clock); #1; end
    chk("basic_p0", 32'(ob(0).rgb), 32'h000000);
    chk("basic_p1", 32'(ob(1).rgb), 32'hFEFEFE);
    chk("basic_cnt", 32'(obs.size()), 32'd2);

    // Saturation
    obs.delete();
    send_word(32'hFF80_FFFF, 1'b0);
    wait_obs(2);
    chk("sat_p0", 32'(ob(0).rgb), 32'hFFAEFF);
    chk("sat_p1", 32'(ob(1).rgb), 32'hFFAEFF);

    // Back to origin, then sof on the word at x=2
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    wait_drain();
    obs.delete();
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b0);
    wait_obs(6);
    for (int i = 0; i < 6; i++) eolv[i] = ob(i).eol;
    chk("rs_sof", 32'(ob(2).sof), 32'd1);
    chk("rs_eol", 32'(eolv[5:0]), 32'h20);
    chk("rs_err", 32'(bus.sync_err), 32'd1);

    // Backpressure: 5-cycle stall mid-stream
    wait_drain();
    obs.delete();
    fork
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
      begin
        repeat (3) begin @(posedge clock); #1; end
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) begin @(posedge clock); #1; end
        bus.out_ready = 1'b1;
      end
    join
    wait_obs(8);
    repeat (4) begin @(posedge clock); #1; end
    chk("bp_count", 32'(obs.size()), 32'd8);
    chk("bp_err_sticky", 32'(bus.sync_err), 32'd1);

    // Random traffic with random backpressure and occasional sof
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          send_word($urandom, $urandom_range(0, 7) == 0);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clock); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset while in P1 with a pending pixel
    bus.out_ready = 1'b0;
    send_word($urandom, 1'b0);
    @(posedge clock); #1;
    chk("prerst_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_err", 32'(bus.sync_err), 32'd0);
    q.delete(); mx = 0; my = 0; merr = 1'b0;
    @(negedge clock); #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    obs.delete();
    @(posedge clock); #1;
    chk("postrst_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h5A40_A0C0, 1'b0);
    wait_obs(2);
    chk("postrst_sof", 32'(ob(0).sof), 32'd1);
    chk("postrst_p1", 32'({ob(1).sof, ob(1).eol}), 32'd0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
